rect_blitter: RTL and testbench
===============================

# rect_blitter

Pixel-generation stage that sits directly upstream of the 160x120, 3-bit-colour VGA adapter. It accepts one rectangle draw request at a time (bird, wall segments, erase boxes) over a valid/ready handshake and clips it to the screen. It then emits one pixel per clock as x/y/colour/plot for the adapter's write port, and pulses `done` when the rectangle is finished so the game controller can sequence its erase/draw passes.

## Interface
- `SCREEN_W`, 160, visible width in pixels; x outputs are always < `SCREEN_W`.
- `SCREEN_H`, 120, visible height in pixels; y outputs are always < `SCREEN_H`.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `req_valid`  in  1  draw request present.
- `req_ready`  out  1  block can accept a request; high exactly when the FSM is in IDLE.
- `req_x0`  in  8  left column of the rectangle.
- `req_y0`  in  7  top row of the rectangle.
- `req_w`  in  8  width in pixels (0..255).
- `req_h`  in  7  height in pixels (0..127).
- `req_colour`  in  3  fill colour {R,G,B}.
- `x`  out  8  pixel column to the adapter.
- `y`  out  7  pixel row to the adapter.
- `colour`  out  3  pixel colour to the adapter.
- `plot`  out  1  write enable to the adapter; one pixel per high cycle.
- `done`  out  1  one-cycle pulse when a request (including an empty one) completes.

## Operation
- FSM states: IDLE, CLIP, DRAW, DONE. Reset forces IDLE.
- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `done`=0, `req_ready`=1 (IDLE).
- IDLE:
  - `req_valid && req_ready` latches x0/y0/w/h/colour; go to CLIP.
  - Inputs are ignored while `req_ready` is 0.
- CLIP:
  - If x0 ≥ `SCREEN_W`, y0 ≥ `SCREEN_H`, w=0 or h=0, the request is empty; go to DONE.
  - Otherwise Wc = min(w, `SCREEN_W`−x0) and Hc = min(h, `SCREEN_H`−y0), computed in 9-bit unsigned so nothing wraps; go to DRAW.
- DRAW:
  - Raster order, x fastest: (x0..x0+Wc−1, y0), then the next row, through row y0+Hc−1.
  - `plot`=1 with registered `x`, `y` and `colour` each cycle.
  - After the last pixel, go to DONE.
- DONE: `done`=1 for one cycle, `plot`=0; go to IDLE.
- `plot` is 0 in every state except DRAW. `x`/`y` hold their last values when `plot` is 0.
- Reset asserted during CLIP/DRAW/DONE:
  - Next cycle is IDLE with reset values.
  - No `done` pulse; the partial rectangle is abandoned.

## Timing
- Handshake accepted at edge N.
- CLIP at N+1. Pixel k (0-based) is presented at N+2+k.
- Last pixel at N+1+Wc·Hc. `done` at N+2+Wc·Hc. `req_ready`=1 again at N+3+Wc·Hc.
- Empty request: `done` at N+2, `req_ready` at N+3, no plot.
- Minimum request-to-request spacing is Wc·Hc+3 cycles. There is no back-pressure from the adapter; it accepts every plot.

## Configuration
- `RECT_BLITTER_CLEAR_EN` defined: adds input `clear_req` (1 bit).
  - `clear_req` is sampled only in IDLE and has priority over `req_valid` in the same cycle (that request is not accepted and `req_ready` drops).
  - It runs a full-screen fill of colour 3'b000: x0=0, y0=0, Wc=`SCREEN_W`, Hc=`SCREEN_H`, giving 19200 plots.
  - Timing and `done` behave exactly as for a normal request.
- `RECT_BLITTER_CLEAR_EN` undefined: the `clear_req` port and clear logic are absent; behaviour is otherwise identical.

## Test plan
- 2x2 request at x0=10, y0=20, colour 3'b110 accepted at N -> plot at N+2..N+5 with (10,20), (11,20), (10,21), (11,21), colour 6; `done` at N+6; `req_ready` at N+7.
- Clip: x0=158, y0=118, w=5, h=4 -> exactly 4 plots, (158,118), (159,118), (158,119), (159,119); no x ≥ 160 or y ≥ 120 ever driven with `plot`=1.
- Empty requests: w=0, then x0=200 -> zero plots; `done` at N+2 in each case.
- Reset for one cycle at the 3rd pixel of a 4x4 draw -> `plot`=0 the next cycle; `done` never pulses; `req_ready`=1; a new 1x1 at (0,0) then plots at its N+2.
- Back-to-back: `req_valid` held high with two 1x1 requests -> second accepted exactly when `req_ready` returns; two `done` pulses 4 cycles apart.
- With `RECT_BLITTER_CLEAR_EN`: `clear_req` and `req_valid` asserted together -> 19200 plots of colour 0 covering (0,0)..(159,119) in raster order; the request is not accepted; `done` at N+19202.

Source files
------------

// File: rtl/rect_blitter.sv
// -----------------------------------------------------------------------------
// rect_blitter
//
// Takes one rectangle draw request at a time over a valid/ready handshake.
// Each request is clipped to the visible screen. The block then emits one
// pixel per clock, in raster order, to the write port of a 160x120, 3-bit
// colour VGA adapter. It pulses `done` once the rectangle is finished, and
// also for a request that clips away to nothing.
//
// Build option:
//   RECT_BLITTER_CLEAR_EN  adds the `clear_req` input. A clear request runs
//                          a full-screen fill in colour 0. It is sampled only
//                          in IDLE and wins over `req_valid` in the same cycle.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   clear_req    in   full-screen clear request (only with RECT_BLITTER_CLEAR_EN)
//   req_valid    in   draw request present
//   req_ready    out  request can be accepted (block is idle)
//   req_x0/y0    in   top-left corner of the rectangle
//   req_w/h      in   rectangle size in pixels
//   req_colour   in   fill colour {R,G,B}
//   x/y/colour   out  registered pixel position and colour for the adapter
//   plot         out  adapter write enable, one pixel per high cycle
//   done         out  one-cycle pulse when a request completes
//
// State table:
//   IDLE | waiting for a request, req_ready high
//   CLIP | request latched; clip size computed, first pixel loaded
//   DRAW | one pixel presented per cycle, plot high
//   DONE | done pulse, back to IDLE next cycle
// -----------------------------------------------------------------------------
module rect_blitter #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
`ifdef RECT_BLITTER_CLEAR_EN
  input  logic       clear_req,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x0,
  input  logic [6:0] req_y0,
  input  logic [7:0] req_w,
  input  logic [6:0] req_h,
  input  logic [2:0] req_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
  localparam logic [8:0] SCR_H9 = 9'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e     state_q, state_d;

  logic [7:0] x0_q, w_q;
  logic [6:0] y0_q, h_q;
  logic [2:0] col_q;
  logic [8:0] x_end_q, y_end_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;

  logic       load_req, load_clear;
  logic [8:0] rem_w, rem_h, wc, hc, x_end_d, y_end_d;
  logic       empty_req;
  logic       last_col, last_row, last_px;

  // Handshake and clear arbitration. A clear takes the idle slot, so
  // req_ready drops in the same cycle and a coincident request is not taken.
`ifdef RECT_BLITTER_CLEAR_EN
  assign load_clear = (state_q == S_IDLE) && clear_req;
`else
  assign load_clear = 1'b0;
`endif
  assign load_req = req_valid && req_ready;

  // Clip arithmetic is done at 9 bits so that x0+w and y0+h cannot wrap.
  // The results are meaningful only when the request is not empty.
  always_comb begin
    rem_w     = SCR_W9 - {1'b0, x0_q};
    rem_h     = SCR_H9 - {2'b00, y0_q};
    wc        = ({1'b0, w_q} < rem_w) ? {1'b0, w_q} : rem_w;
    hc        = ({2'b00, h_q} < rem_h) ? {2'b00, h_q} : rem_h;
    x_end_d   = {1'b0, x0_q} + wc - 9'd1;
    y_end_d   = {2'b00, y0_q} + hc - 9'd1;
    empty_req = ({1'b0, x0_q} >= SCR_W9) || ({2'b00, y0_q} >= SCR_H9) ||
                (w_q == 8'd0) || (h_q == 7'd0);
  end

  assign last_col = ({1'b0, x_q} == x_end_q);
  assign last_row = ({2'b00, y_q} == y_end_q);
  assign last_px  = last_col && last_row;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load_req || load_clear) state_d = S_CLIP;
      S_CLIP: state_d = empty_req ? S_DONE : S_DRAW;
      S_DRAW: if (last_px) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and raster walk. x/y/colour only change when the next
  // pixel is loaded, so they hold their values whenever plot is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_clear) begin
            x0_q  <= '0;
            y0_q  <= '0;
            w_q   <= 8'(SCREEN_W);
            h_q   <= 7'(SCREEN_H);
            col_q <= 3'b000;
          end else if (load_req) begin
            x0_q  <= req_x0;
            y0_q  <= req_y0;
            w_q   <= req_w;
            h_q   <= req_h;
            col_q <= req_colour;
          end
        end
        S_CLIP: begin
          if (!empty_req) begin
            x_q      <= x0_q;
            y_q      <= y0_q;
            colour_q <= col_q;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
          end
        end
        S_DRAW: begin
          if (!last_px) begin
            if (last_col) begin
              x_q <= x0_q;
              y_q <= y_q + 7'd1;
            end else begin
              x_q <= x_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == S_IDLE);
`ifdef RECT_BLITTER_CLEAR_EN
    req_ready = (state_q == S_IDLE) && !clear_req;
`endif
    plot   = (state_q == S_DRAW);
    done   = (state_q == S_DONE);
    x      = x_q;
    y      = y_q;
    colour = colour_q;
  end

endmodule

// File: tb/tb_rect_blitter.sv
module tb_rect_blitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x0 = '0;
  logic [6:0] req_y0 = '0;
  logic [7:0] req_w = '0;
  logic [6:0] req_h = '0;
  logic [2:0] req_colour = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
`ifdef RECT_BLITTER_CLEAR_EN
  logic       clear_req = 1'b0;
`endif

  rect_blitter dut (
    .clk        (clk),
    .reset      (reset),
`ifdef RECT_BLITTER_CLEAR_EN
    .clear_req  (clear_req),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x0     (req_x0),
    .req_y0     (req_y0),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   oob_cnt = 0;
  logic prev_ready = 1'b1;
  pix_t plot_q[$];
  pix_t exp_q[$];
  int   done_q[$];
  int   rdy_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      plot_q.push_back(pix_t'{cyc, x, y, colour});
      if (x >= 8'd160 || y >= 7'd120) oob_cnt++;
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (req_ready === 1'b1 && prev_ready !== 1'b1) rdy_q.push_back(cyc);
    prev_ready = req_ready;
  end

  // Reference: every on-screen point of the rectangle in raster order.
  // Pixel k is expected on the cycle after edge e+1+k.
  task automatic build_exp(input int x0, input int y0, input int w, input int h,
                           input int c, input int e, input bit append);
    int k;
    if (!append) exp_q.delete();
    k = 0;
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        if (xx < 160 && yy < 120) begin
          exp_q.push_back(pix_t'{e + 1 + k, 8'(xx), 7'(yy), 3'(c)});
          k++;
        end
  endtask

  function automatic int first_diff();
    int n;
    n = (plot_q.size() < exp_q.size()) ? plot_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (plot_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  function automatic int first_rdy();
    return (rdy_q.size() > 0) ? rdy_q[0] : -1;
  endfunction

  // Presents a request; e is the clock edge at which it is accepted (-1 if never)
  task automatic issue_req(input int x0, input int y0, input int w, input int h,
                           input int c, output int e);
    @(posedge clk); #1;
    plot_q.delete(); done_q.delete(); rdy_q.delete();
    req_x0 = 8'(x0); req_y0 = 7'(y0); req_w = 8'(w); req_h = 7'(h);
    req_colour = 3'(c); req_valid = 1'b1;
    e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        e = cyc + 1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_q.size() == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (x !== 8'd0) begin failures++; $display("FAIL reset_x got=%0d want=0", x); end
    checks++; if (y !== 7'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", y); end
    checks++; if (colour !== 3'd0) begin failures++; $display("FAIL reset_colour got=%0d want=0", colour); end
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%b want=0", plot); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_2x2();
    int e, d;
    issue_req(10, 20, 2, 2, 6, e);
    build_exp(10, 20, 2, 2, 6, e, 1'b0);
    wait_done(100);
    checks++; if (plot_q.size() != 4) begin failures++; $display("FAIL 2x2_count got=%0d want=4", plot_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL 2x2_pixel[%0d] got (%0d,%0d,c%0d)@%0d want (%0d,%0d,c%0d)@%0d", d,
               plot_q[d].px, plot_q[d].py, plot_q[d].pc, plot_q[d].cyc,
               exp_q[d].px, exp_q[d].py, exp_q[d].pc, exp_q[d].cyc);
    end
    checks++; if (first_done() != e + 5) begin failures++; $display("FAIL 2x2_done got=%0d want=%0d", first_done(), e + 5); end
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL 2x2_done_count got=%0d want=1", done_q.size()); end
    checks++; if (first_rdy() != e + 6) begin failures++; $display("FAIL 2x2_ready got=%0d want=%0d", first_rdy(), e + 6); end
  endtask

  task automatic test_clip();
    int e, d;
    oob_cnt = 0;
    issue_req(158, 118, 5, 4, 3, e);
    build_exp(158, 118, 5, 4, 3, e, 1'b0);
    wait_done(100);
    checks++; if (plot_q.size() != exp_q.size()) begin failures++; $display("FAIL clip_count got=%0d want=%0d", plot_q.size(), exp_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL clip_pixel[%0d] got (%0d,%0d,c%0d)@%0d want (%0d,%0d,c%0d)@%0d", d,
               plot_q[d].px, plot_q[d].py, plot_q[d].pc, plot_q[d].cyc,
               exp_q[d].px, exp_q[d].py, exp_q[d].pc, exp_q[d].cyc);
    end
    checks++; if (oob_cnt != 0) begin failures++; $display("FAIL clip_offscreen got=%0d want=0", oob_cnt); end
    checks++; if (first_done() != e + 1 + exp_q.size()) begin failures++; $display("FAIL clip_done got=%0d want=%0d", first_done(), e + 1 + exp_q.size()); end
  endtask

  task automatic test_empty();
    int e;
    int cases[2][4] = '{'{5, 5, 0, 3}, '{200, 10, 4, 4}};
    for (int t = 0; t < 2; t++) begin
      issue_req(cases[t][0], cases[t][1], cases[t][2], cases[t][3], 5, e);
      wait_done(50);
      checks++; if (plot_q.size() != 0) begin failures++; $display("FAIL empty%0d_count got=%0d want=0", t, plot_q.size()); end
      checks++; if (first_done() != e + 1) begin failures++; $display("FAIL empty%0d_done got=%0d want=%0d", t, first_done(), e + 1); end
      checks++; if (first_rdy() != e + 2) begin failures++; $display("FAIL empty%0d_ready got=%0d want=%0d", t, first_rdy(), e + 2); end
    end
  endtask

  task automatic test_mid_reset();
    int e, d;
    issue_req(30, 40, 4, 4, 2, e);
    build_exp(30, 40, 4, 4, 2, e, 1'b0);
    // now just after edge e; pixel 2 is presented after edge e+3
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL rst_plot got=%b want=0", plot); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    checks++; if (x !== 8'd0 || y !== 7'd0) begin failures++; $display("FAIL rst_xy got=(%0d,%0d) want=(0,0)", x, y); end
    repeat (20) @(negedge clk);
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL rst_no_done got=%0d want=0", done_q.size()); end
    checks++; if (plot_q.size() != 3) begin failures++; $display("FAIL rst_partial_count got=%0d want=3", plot_q.size()); end
    d = first_diff();
    checks++; if (d != -1) begin failures++; $display("FAIL rst_partial_pixel[%0d] got (%0d,%0d) want (%0d,%0d)", d, plot_q[d].px, plot_q[d].py, exp_q[d].px, exp_q[d].py); end
    issue_req(0, 0, 1, 1, 7, e);
    build_exp(0, 0, 1, 1, 7, e, 1'b0);
    wait_done(50);
    d = first_diff();
    checks++; if (plot_q.size() != 1 || d != -1) begin failures++; $display("FAIL rst_after_1x1 got count=%0d diff=%0d want count=1 diff=-1", plot_q.size(), d); end
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    e1 = -1; e2 = -1;
    @(posedge clk); #1;
    plot_q.delete(); done_q.delete(); rdy_q.delete();
    req_x0 = 8'd5; req_y0 = 7'd6; req_w = 8'd1; req_h = 7'd1; req_colour = 3'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin e1 = cyc + 1; break; end
    end
    @(posedge clk); #1;
    req_x0 = 8'd7; req_y0 = 7'd8; req_colour = 3'd5;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin e2 = cyc + 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 50 && done_q.size() < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    build_exp(5, 6, 1, 1, 3, e1, 1'b0);
    build_exp(7, 8, 1, 1, 5, e2, 1'b1);
    checks++; if (e2 != e1 + 4) begin failures++; $display("FAIL b2b_accept got=%0d want=%0d", e2, e1 + 4); end
    checks++; if (done_q.size() != 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", done_q.size()); end
    else begin
      checks++; if (done_q[0] != e1 + 2) begin failures++; $display("FAIL b2b_done0 got=%0d want=%0d", done_q[0], e1 + 2); end
      checks++; if (done_q[1] - done_q[0] != 4) begin failures++; $display("FAIL b2b_done_gap got=%0d want=4", done_q[1] - done_q[0]); end
    end
    checks++; if (plot_q.size() != 2 || first_diff() != -1) begin failures++; $display("FAIL b2b_pixels got count=%0d diff=%0d want count=2 diff=-1", plot_q.size(), first_diff()); end
  endtask

  task automatic test_random();
    int e, d, x0, y0, w, h, c;
    oob_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      x0 = int'($urandom_range(0, 175));
      y0 = int'($urandom_range(0, 127));
      w  = int'($urandom_range(0, 24));
      h  = int'($urandom_range(0, 12));
      c  = int'($urandom_range(0, 7));
      issue_req(x0, y0, w, h, c, e);
      build_exp(x0, y0, w, h, c, e, 1'b0);
      wait_done(1000);
      checks++; if (plot_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count (%0d,%0d,%0dx%0d) got=%0d want=%0d", t, x0, y0, w, h, plot_q.size(), exp_q.size()); end
      d = first_diff();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL rand%0d_pixel[%0d] got (%0d,%0d,c%0d)@%0d want (%0d,%0d,c%0d)@%0d", t, d,
                 plot_q[d].px, plot_q[d].py, plot_q[d].pc, plot_q[d].cyc,
                 exp_q[d].px, exp_q[d].py, exp_q[d].pc, exp_q[d].cyc);
      end
      checks++; if (first_done() != e + 1 + exp_q.size()) begin failures++; $display("FAIL rand%0d_done got=%0d want=%0d", t, first_done(), e + 1 + exp_q.size()); end
      checks++; if (first_rdy() != e + 2 + exp_q.size()) begin failures++; $display("FAIL rand%0d_ready got=%0d want=%0d", t, first_rdy(), e + 2 + exp_q.size()); end
    end
    checks++; if (oob_cnt != 0) begin failures++; $display("FAIL rand_offscreen got=%0d want=0", oob_cnt); end
  endtask

`ifdef RECT_BLITTER_CLEAR_EN
  task automatic test_clear();
    int e, d;
    @(posedge clk); #1;
    plot_q.delete(); done_q.delete(); rdy_q.delete();
    req_x0 = 8'd12; req_y0 = 7'd13; req_w = 8'd2; req_h = 7'd2; req_colour = 3'd5;
    req_valid = 1'b1; clear_req = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL clear_ready_drop got=%b want=0", req_ready); end
    @(posedge clk); #1;
    clear_req = 1'b0; req_valid = 1'b0;
    build_exp(0, 0, 160, 120, 0, e, 1'b0);
    wait_done(20000);
    checks++; if (plot_q.size() != 19200) begin failures++; $display("FAIL clear_count got=%0d want=19200", plot_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL clear_pixel[%0d] got (%0d,%0d,c%0d)@%0d want (%0d,%0d,c%0d)@%0d", d,
               plot_q[d].px, plot_q[d].py, plot_q[d].pc, plot_q[d].cyc,
               exp_q[d].px, exp_q[d].py, exp_q[d].pc, exp_q[d].cyc);
    end
    checks++; if (first_done() != e + 19201) begin failures++; $display("FAIL clear_done got=%0d want=%0d", first_done(), e + 19201); end
    checks++; if (first_rdy() != e + 19202) begin failures++; $display("FAIL clear_ready got=%0d want=%0d", first_rdy(), e + 19202); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_2x2();
    test_clip();
    test_empty();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef RECT_BLITTER_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
